// File: rtl/kpg_sum_decode.sv
// kpg_sum_decode: final stage of the 8-bit recursive-doubling adder.
// Decodes resolved kill/propagate/generate codes into the carry chain,
// forms the sum and ALU flags, and flags unresolved codes. Two-register
// valid/ready pipeline (S1 = operands/codes, S2 = decoded result).
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; valid never depends on ready, data is held stable while valid
// is high and ready is low, and in_ready is combinational from out_ready.
module kpg_sum_decode (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        cin,
  input  logic [15:0] kpg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  sum,
  output logic        cout,
  output logic        ovf,
  output logic        zero,
  output logic        neg,
  output logic        err,
  output logic        err_sticky,
  input  logic        clr_err
);

  // S1 stage: captured operands and codes
  logic        s1_v_q, s1_v_d;
  logic [7:0]  a_q, b_q;
  logic        cin_q;
  logic [15:0] kpg_q;

  // S2 stage: decoded result
  logic        s2_v_q, s2_v_d;
  logic [7:0]  sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;
  logic        zero_q, zero_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic        err_sticky_q, err_sticky_d;

  logic        s2_load;
  logic        accept;
  logic        handoff;
  logic [8:0]  carry;
  logic [1:0]  code;

  assign s2_load  = !s2_v_q || out_ready;
  assign in_ready = !s1_v_q || s2_load;
  assign accept   = in_valid && in_ready;
  assign handoff  = s2_v_q && out_ready;

  // Decode the code pairs held in S1 into carries, sum, flags and error
  always_comb begin
    carry    = '0;
    carry[0] = cin_q;
    code     = 2'b00;
    err_d    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      code         = kpg_q[2*i +: 2];
      // Unresolved (propagate) pairs decode as carry 0 and mark the result.
      carry[i+1]   = (code == 2'b11);
      if (code == 2'b01 || code == 2'b10) err_d = 1'b1;
    end
    sum_d  = a_q ^ b_q ^ carry[7:0];
    cout_d = carry[8];
    ovf_d  = carry[7] ^ carry[8];
    zero_d = (sum_d == 8'h00);
    neg_d  = sum_d[7];
  end

  // Next-state of the stage valid flags and the sticky error
  always_comb begin
    s1_v_d = s1_v_q;
    if (accept)       s1_v_d = 1'b1;
    else if (s2_load) s1_v_d = 1'b0;

    s2_v_d = s2_v_q;
    if (s2_load) s2_v_d = s1_v_q;

    // A flagged result being handed off beats a simultaneous clear.
    err_sticky_d = err_sticky_q;
    if (handoff && err_q) err_sticky_d = 1'b1;
    else if (clr_err)     err_sticky_d = 1'b0;
  end

  // Valid flags and sticky error register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q       <= 1'b0;
      s2_v_q       <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      s1_v_q       <= s1_v_d;
      s2_v_q       <= s2_v_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // S1 data register: loads on every accepted input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      kpg_q <= '0;
    end else if (accept) begin
      a_q   <= a;
      b_q   <= b;
      cin_q <= cin;
      kpg_q <= kpg;
    end
  end

  // S2 data register: loads the decoded S1 contents when S1 advances
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (s2_load && s1_v_q) begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      neg_q  <= neg_d;
      err_q  <= err_d;
    end
  end

  assign out_valid  = s2_v_q;
  assign sum        = sum_q;
  assign cout       = cout_q;
  assign ovf        = ovf_q;
  assign zero       = zero_q;
  assign neg        = neg_q;
  assign err        = err_q;
  assign err_sticky = err_sticky_q;

endmodule

// File: tb/tb_kpg_sum_decode.sv
// Testbench for kpg_sum_decode: directed steps plus a random stream,
// with an expected-result queue checked on every output handoff.
module tb_kpg_sum_decode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic [15:0] kpg;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  sum;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic        neg;
  logic        err;
  logic        err_sticky;
  logic        clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Result word: {sum, cout, ovf, zero, neg, err}
  logic [12:0] exp_q[$];

  kpg_sum_decode dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .cin        (cin),
    .kpg        (kpg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sum        (sum),
    .cout       (cout),
    .ovf        (ovf),
    .zero       (zero),
    .neg        (neg),
    .err        (err),
    .err_sticky (err_sticky),
    .clr_err    (clr_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [12:0] model(input logic [7:0] ma, input logic [7:0] mb,
                                        input logic mcin, input logic [15:0] mk);
    logic [8:0] c;
    logic [7:0] s;
    logic       e;
    c[0] = mcin;
    e    = 1'b0;
    for (int i = 0; i < 8; i++) begin
      case ({mk[2*i+1], mk[2*i]})
        2'b00:   c[i+1] = 1'b0;
        2'b11:   c[i+1] = 1'b1;
        default: begin c[i+1] = 1'b0; e = 1'b1; end
      endcase
    end
    for (int i = 0; i < 8; i++) s[i] = ma[i] ^ mb[i] ^ c[i];
    return {s, c[8], c[7] ^ c[8], (s == 8'h00), s[7], e};
  endfunction

  function automatic logic [12:0] dut_word();
    return {sum, cout, ovf, zero, neg, err};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] da, input logic [7:0] db,
                       input logic dcin, input logic [15:0] dk);
    a        = da;
    b        = db;
    cin      = dcin;
    kpg      = dk;
    in_valid = 1'b1;
  endtask

  // Send one input (out_ready high), then advance to the cycle where it is in S2.
  task automatic send_one(input logic [7:0] da, input logic [7:0] db,
                          input logic dcin, input logic [15:0] dk);
    drive(da, db, dcin, dk);
    tick();
    in_valid = 1'b0;
    chk("latency_s1_only", {15'd0, out_valid}, 16'd0);
    tick();
    chk("latency_out_valid", {15'd0, out_valid}, 16'd1);
  endtask

  // ---------------- scoreboard monitor ----------------
  // Inputs change just after posedge, so negedge sees what the next edge will act on.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {3'd0, dut_word()}, 16'h1fff);
        end else begin
          chk("scoreboard", {3'd0, dut_word()}, {3'd0, exp_q.pop_front()});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, kpg));
    end
  end

  // ---------------- directed sequence ----------------
  logic [12:0] held;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    a = '0; b = '0; cin = 1'b0; kpg = '0;
    repeat (3) tick();
    chk("reset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("reset_outputs", {3'd0, dut_word()}, 16'd0);
    chk("reset_err_sticky", {15'd0, err_sticky}, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("in_ready_after_reset", {15'd0, in_ready}, 16'd1);

    // Known-answer vectors
    out_ready = 1'b1;
    send_one(8'h35, 8'h4A, 1'b0, 16'h0000);
    chk("kat_35_4a", {3'd0, dut_word()}, {3'd0, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    tick();
    send_one(8'hFF, 8'h01, 1'b0, 16'hFFFF);
    chk("kat_ff_01", {3'd0, dut_word()}, {3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
    tick();
    send_one(8'h7F, 8'h01, 1'b0, 16'h3FFF);
    chk("kat_7f_01", {3'd0, dut_word()}, {3'd0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0});
    tick();

    // Unresolved code and sticky error
    send_one(8'h00, 8'h00, 1'b0, 16'h0001);
    chk("unres_result", {3'd0, dut_word()}, {3'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1});
    chk("sticky_before_handoff", {15'd0, err_sticky}, 16'd0);
    tick();
    chk("sticky_set", {15'd0, err_sticky}, 16'd1);
    send_one(8'h12, 8'h21, 1'b0, 16'h0000);
    tick();
    chk("sticky_holds", {15'd0, err_sticky}, 16'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("sticky_cleared", {15'd0, err_sticky}, 16'd0);

    // Clear coincides with a flagged handoff: set wins
    send_one(8'h00, 8'h00, 1'b0, 16'h8000);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("sticky_set_wins", {15'd0, err_sticky}, 16'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("sticky_cleared_again", {15'd0, err_sticky}, 16'd0);

    // Backpressure: two buffered, third refused, then drain in order
    out_ready = 1'b0;
    drive(8'h01, 8'h10, 1'b0, 16'h0000);
    tick();
    drive(8'h02, 8'h20, 1'b0, 16'h0000);
    tick();
    drive(8'h03, 8'h30, 1'b0, 16'h0000);
    chk("full_in_ready_low", {15'd0, in_ready}, 16'd0);
    held = dut_word();
    chk("bp_first_result", {3'd0, held}, {3'd0, 8'h11, 5'b00000});
    tick();
    chk("bp_in_ready_still_low", {15'd0, in_ready}, 16'd0);
    chk("bp_stable", {3'd0, dut_word()}, {3'd0, held});
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("drain_1_valid", {15'd0, out_valid}, 16'd1);
    chk("drain_1_data", {8'd0, sum}, 16'h0022);
    tick();
    chk("drain_2_valid", {15'd0, out_valid}, 16'd1);
    chk("drain_2_data", {8'd0, sum}, 16'h0033);
    tick();
    chk("drain_done", {15'd0, out_valid}, 16'd0);

    // Random stream with random backpressure
    for (int n = 0; n < 300; n++) begin
      if (!in_valid || in_ready) begin
        if ($urandom_range(0, 3) != 0)
          drive(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)));
        else
          in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    chk("random_drained", 16'(exp_q.size()), 16'd0);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    drive(8'h55, 8'h0A, 1'b1, 16'hFFFF);
    tick();
    drive(8'h66, 8'h11, 1'b0, 16'h00FF);
    tick();
    in_valid = 1'b0;
    chk("pre_reset_valid", {15'd0, out_valid}, 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("mid_reset_out_valid", {15'd0, out_valid}, 16'd0);
    chk("mid_reset_outputs", {3'd0, dut_word()}, 16'd0);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk("no_stale_after_reset", {15'd0, out_valid}, 16'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
